// File: rtl/pwm_ramp_controller_if.sv
// Configuration write bus for pwm_ramp_controller: one-cycle write strobe plus
// channel/register select and data.
interface pwm_ramp_controller_if #(
    parameter int CH_BITS = 2,
    parameter int WIDTH   = 8
);
    // No ready: a cycle with cfg_write=1 is a complete write and is always accepted.
    logic               cfg_write;
    logic [CH_BITS-1:0] cfg_channel;
    logic               cfg_select;
    logic [WIDTH-1:0]   cfg_data;

    modport master (output cfg_write, cfg_channel, cfg_select, cfg_data);
    modport slave  (input  cfg_write, cfg_channel, cfg_select, cfg_data);
endinterface

// File: rtl/pwm_ramp_controller.sv
// Multi-channel PWM with a shared prescaled timebase; each channel's duty ramps
// toward its target by STEP once per period boundary.
module pwm_ramp_controller #(
    parameter int          CHANNELS = 4,
    parameter int          CH_BITS  = 2,
    parameter int          WIDTH    = 8,
    parameter int unsigned DIV      = 16,
    parameter int unsigned TOP      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    pwm_ramp_controller_if.slave      cfg,
    input  logic                      i_enable,
    input  logic [CHANNELS-1:0]       i_done_clear,
    output logic [CHANNELS-1:0]       o_done,
    output logic [CHANNELS*WIDTH-1:0] o_current_value,
    output logic                      o_period_start,
    output logic [CHANNELS-1:0]       o_pwm_out,
    output logic [2*CHANNELS-1:0]     o_dbg_state
);

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_UP   = 2'd1,
        CH_DOWN = 2'd2
    } ch_state_e;

    localparam longint unsigned FULL   = 64'd1 << WIDTH;
    localparam longint unsigned PERIOD = (TOP == 0 || 64'(TOP) >= FULL) ? FULL : 64'(TOP);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(PERIOD - 1);

    logic             w_tick;
    logic             w_boundary;
    logic [WIDTH-1:0] r_count;
    logic             r_period_start;

    generate
        if (DIV == 0) begin : g_nodiv
            assign w_tick = i_enable;
        end else begin : g_div
            logic [DIV-1:0] r_presc;
            // Held at zero while disabled so re-enabling starts a full prescale.
            always_ff @(posedge clk) begin
                if (rst || !i_enable) r_presc <= '0;
                else                  r_presc <= r_presc + 1'b1;
            end
            assign w_tick = i_enable & (&r_presc);
        end
    endgenerate

    assign w_boundary = w_tick && (r_count == LAST);

    always_ff @(posedge clk) begin
        if (rst || !i_enable)  r_count <= '0;
        else if (w_boundary)   r_count <= '0;
        else if (w_tick)       r_count <= r_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_period_start <= 1'b0;
        else     r_period_start <= w_boundary;
    end

    logic [WIDTH-1:0]  r_target  [CHANNELS];
    logic [WIDTH-1:0]  r_step    [CHANNELS];
    logic [WIDTH-1:0]  r_current [CHANNELS];
    logic [CHANNELS-1:0] r_done;

    ch_state_e         w_state [CHANNELS];
    logic [WIDTH:0]    w_sum   [CHANNELS];
    logic [WIDTH-1:0]  w_next  [CHANNELS];
    logic [CHANNELS-1:0] w_set;

    // Next duty saturates at the target in both directions; the sum carries an
    // extra bit so an upward step can never wrap.
    always_comb begin
        w_set = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_state[i] = (r_current[i] < r_target[i]) ? CH_UP :
                         (r_current[i] > r_target[i]) ? CH_DOWN : CH_IDLE;
            w_sum[i]   = {1'b0, r_current[i]} + {1'b0, r_step[i]};
            w_next[i]  = r_current[i];
            if (r_step[i] == '0) begin
                w_next[i] = r_target[i];
            end else begin
                case (w_state[i])
                    CH_UP:   w_next[i] = (w_sum[i] > {1'b0, r_target[i]}) ?
                                         r_target[i] : w_sum[i][WIDTH-1:0];
                    CH_DOWN: w_next[i] = (r_step[i] > (r_current[i] - r_target[i])) ?
                                         r_target[i] : (r_current[i] - r_step[i]);
                    default: w_next[i] = r_current[i];
                endcase
            end
            w_set[i] = w_boundary && (w_state[i] != CH_IDLE) && (w_next[i] == r_target[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_target[i]  <= '0;
                r_step[i]    <= '0;
                r_current[i] <= '0;
            end
            r_done <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_boundary) r_current[i] <= w_next[i];
                if (cfg.cfg_write && (cfg.cfg_channel == CH_BITS'(i))) begin
                    if (cfg.cfg_select) r_step[i]   <= cfg.cfg_data;
                    else                r_target[i] <= cfg.cfg_data;
                end
            end
            r_done <= (r_done & ~i_done_clear) | w_set;
        end
    end

    always_comb begin
        o_pwm_out       = '0;
        o_current_value = '0;
        o_dbg_state     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            o_pwm_out[i]                    = i_enable & (r_count < r_current[i]);
            o_current_value[i*WIDTH +: WIDTH] = r_current[i];
            o_dbg_state[2*i +: 2]           = w_state[i];
        end
    end

    assign o_done         = r_done;
    assign o_period_start = r_period_start;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: cycle-level reference model of the main
// instance plus directed literal checks, and a second prescaled instance.
module tb_pwm_ramp_controller;
    localparam int W  = 8;
    localparam int CH = 2;
    localparam int CB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main instance: DIV=0, TOP=0 (256-count period)
    logic              rst, en;
    logic [CH-1:0]     dclr;
    logic [CH-1:0]     done, pwm;
    logic [CH*W-1:0]   cur;
    logic              ps;
    logic [2*CH-1:0]   dbg;

    pwm_ramp_controller_if #(.CH_BITS(CB), .WIDTH(W)) bus ();

    pwm_ramp_controller #(.CHANNELS(CH), .CH_BITS(CB), .WIDTH(W), .DIV(0), .TOP(0)) dut (
        .clk(clk), .rst(rst), .cfg(bus), .i_enable(en), .i_done_clear(dclr),
        .o_done(done), .o_current_value(cur), .o_period_start(ps),
        .o_pwm_out(pwm), .o_dbg_state(dbg)
    );

    // Second instance: DIV=2, TOP=200
    logic              rst2, en2;
    logic [1:0]        dclr2;
    logic [1:0]        done2, pwm2;
    logic [2*W-1:0]    cur2;
    logic              ps2;
    logic [3:0]        dbg2;

    pwm_ramp_controller_if #(.CH_BITS(1), .WIDTH(W)) bus2 ();

    pwm_ramp_controller #(.CHANNELS(2), .CH_BITS(1), .WIDTH(W), .DIV(2), .TOP(200)) dut2 (
        .clk(clk), .rst(rst2), .cfg(bus2), .i_enable(en2), .i_done_clear(dclr2),
        .o_done(done2), .o_current_value(cur2), .o_period_start(ps2),
        .o_pwm_out(pwm2), .o_dbg_state(dbg2)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d", name, got, got, want);
        end
    endtask

    // Reference model: period position and per-channel registers as integers
    int m_pos;
    int m_tgt  [CH];
    int m_step [CH];
    int m_cur  [CH];
    bit m_done [CH];
    bit m_ps;
    bit chk_en = 1'b0;

    initial begin
        m_pos = 0; m_ps = 0;
        for (int c = 0; c < CH; c++) begin
            m_tgt[c] = 0; m_step[c] = 0; m_cur[c] = 0; m_done[c] = 0;
        end
    end

    always @(posedge clk) begin
        bit b;
        int nxt;
        if (rst) begin
            m_pos = 0; m_ps = 0;
            for (int c = 0; c < CH; c++) begin
                m_tgt[c] = 0; m_step[c] = 0; m_cur[c] = 0; m_done[c] = 0;
            end
        end else begin
            b = en && (m_pos == 255);
            for (int c = 0; c < CH; c++) begin
                nxt = m_cur[c];
                if (b) begin
                    if (m_step[c] == 0)            nxt = m_tgt[c];
                    else if (m_cur[c] < m_tgt[c])  nxt = (m_cur[c] + m_step[c] > m_tgt[c]) ? m_tgt[c] : m_cur[c] + m_step[c];
                    else if (m_cur[c] > m_tgt[c])  nxt = (m_cur[c] - m_step[c] < m_tgt[c]) ? m_tgt[c] : m_cur[c] - m_step[c];
                end
                if (b && m_cur[c] != m_tgt[c] && nxt == m_tgt[c]) m_done[c] = 1;
                else if (dclr[c])                                 m_done[c] = 0;
                m_cur[c] = nxt;
                if (bus.cfg_write && bus.cfg_channel == c) begin
                    if (bus.cfg_select) m_step[c] = int'(bus.cfg_data);
                    else                m_tgt[c]  = int'(bus.cfg_data);
                end
            end
            m_ps  = b;
            m_pos = (!en || b) ? 0 : m_pos + 1;
        end
    end

    always @(negedge clk) begin
        logic [CH*W-1:0] e_cur;
        logic [CH-1:0]   e_done, e_pwm;
        if (chk_en) begin
            for (int c = 0; c < CH; c++) begin
                e_cur[c*W +: W] = W'(m_cur[c]);
                e_done[c]       = m_done[c];
                e_pwm[c]        = en && (m_pos < m_cur[c]);
            end
            check("model_current", cur,  e_cur);
            check("model_done",    done, e_done);
            check("model_pstart",  ps,   m_ps);
            check("model_pwm",     pwm,  e_pwm);
        end
    end

    task automatic cfg_wr(input int ch, input bit sel, input int data);
        @(posedge clk); #1;
        bus.cfg_write   = 1'b1;
        bus.cfg_channel = CB'(ch);
        bus.cfg_select  = sel;
        bus.cfg_data    = W'(data);
        @(posedge clk); #1;
        bus.cfg_write   = 1'b0;
    endtask

    task automatic wait_ps(input string name);
        int n = 0;
        @(negedge clk);
        while (ps !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pstart_seen"}, ps, 1);
    endtask

    // Leaves the bench at posedge+1 of the cycle whose closing edge is a boundary
    task automatic wait_before_b(input string name);
        int n = 0;
        @(posedge clk); #1;
        while (!(en && m_pos == 255) && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 600) begin
            failures++;
            $display("FAIL %s: boundary not reached within %0d cycles", name, n);
        end
    endtask

    task automatic pulse_clear(input logic [CH-1:0] m);
        @(posedge clk); #1; dclr = m;
        @(posedge clk); #1; dclr = '0;
    endtask

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int hi, pc, n, run, maxrun;
        int up_seq [4];
        int dn_seq [3];
        up_seq = '{30, 60, 90, 100};
        dn_seq = '{60, 20, 10};
        rst = 1; en = 0; dclr = '0;
        bus.cfg_write = 0; bus.cfg_channel = '0; bus.cfg_select = 0; bus.cfg_data = '0;
        rst2 = 1; en2 = 0; dclr2 = '0;
        bus2.cfg_write = 0; bus2.cfg_channel = '0; bus2.cfg_select = 0; bus2.cfg_data = '0;

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("reset_current", cur, 0);
        check("reset_done", done, 0);
        check("reset_pstart", ps, 0);
        check("reset_pwm", pwm, 0);
        @(posedge clk); #1 rst = 0;

        // 1: immediate set
        cfg_wr(0, 0, 64);
        @(posedge clk); #1 en = 1;
        wait_ps("t1");
        check("t1_cur0", cur[7:0], 64);
        check("t1_done0", done[0], 1);
        hi = 0; pc = 0;
        for (int k = 0; k < 256; k++) begin
            if (pwm[0]) hi++;
            if (k > 0 && ps) pc++;
            @(negedge clk);
        end
        check("t1_duty_high", hi, 64);
        check("t1_no_early_pstart", pc, 0);
        check("t1_period_256", ps, 1);

        // 2: ramp up
        cfg_wr(1, 1, 30);
        cfg_wr(1, 0, 100);
        for (int k = 0; k < 4; k++) begin
            wait_ps("t2");
            check("t2_ramp_cur1", cur[15:8], up_seq[k]);
            check("t2_done1", done[1], (k == 3) ? 1 : 0);
        end
        wait_ps("t2b");
        check("t2_done_sticky", done[1], 1);
        pulse_clear(2'b10);
        @(negedge clk);
        check("t2_done_cleared", done[1], 0);

        // 3: ramp down and saturation
        cfg_wr(1, 1, 40);
        cfg_wr(1, 0, 10);
        for (int k = 0; k < 3; k++) begin
            wait_ps("t3");
            check("t3_down_cur1", cur[15:8], dn_seq[k]);
        end
        cfg_wr(1, 1, 200);
        cfg_wr(1, 0, 0);
        wait_ps("t3z");
        check("t3_down_sat_zero", cur[15:8], 0);
        cfg_wr(1, 1, 0);
        cfg_wr(1, 0, 200);
        wait_ps("t3s");
        check("t3_set_200", cur[15:8], 200);
        cfg_wr(1, 1, 100);
        cfg_wr(1, 0, 255);
        wait_ps("t3u");
        check("t3_up_sat_255", cur[15:8], 255);

        // 4a: done_clear coinciding with done set
        pulse_clear(2'b10);
        cfg_wr(1, 1, 0);
        cfg_wr(1, 0, 50);
        wait_before_b("t4a");
        dclr = 2'b10;
        @(posedge clk); #1 dclr = '0;
        @(negedge clk);
        check("t4a_set_wins", done[1], 1);
        check("t4a_cur1", cur[15:8], 50);

        // 4b: target write in the boundary cycle
        cfg_wr(1, 0, 60);
        wait_before_b("t4b");
        bus.cfg_write = 1; bus.cfg_channel = 2'd1; bus.cfg_select = 0; bus.cfg_data = 8'd80;
        @(posedge clk); #1 bus.cfg_write = 0;
        @(negedge clk);
        check("t4b_old_target_used", cur[15:8], 60);
        wait_ps("t4b");
        check("t4b_new_target_next", cur[15:8], 80);

        // 4c: reversal mid-ramp
        cfg_wr(1, 1, 20);
        cfg_wr(1, 0, 200);
        wait_ps("t4c");
        check("t4c_up_step", cur[15:8], 100);
        cfg_wr(1, 0, 0);
        wait_ps("t4c2");
        check("t4c_reversed", cur[15:8], 80);
        check("t4c_dbg_ch1_down", dbg[3:2], 2);

        // 5a: enable drop and re-enable
        repeat (100) @(posedge clk);
        #1 en = 0;
        @(negedge clk);
        check("t5_pwm_off", pwm, 0);
        check("t5_cur_frozen", cur, {8'd80, 8'd64});
        cfg_wr(0, 0, 10);
        pulse_clear(2'b01);
        pc = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ps) pc++;
        end
        check("t5_no_pstart_disabled", pc, 0);
        check("t5_cur_still_frozen", cur, {8'd80, 8'd64});
        check("t5_clear_while_disabled", done[0], 0);
        @(posedge clk); #1 en = 1;
        @(negedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps !== 1'b1 && n < 600);
        check("t5_reenable_period", n, 256);
        check("t5_cur_after_reenable", cur, {8'd60, 8'd10});

        // 5b: reset mid-ramp
        cfg_wr(0, 1, 1);
        cfg_wr(0, 0, 255);
        wait_ps("t5b");
        repeat (30) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        check("t5b_rst_cur", cur, 0);
        check("t5b_rst_done", done, 0);
        check("t5b_rst_pstart", ps, 0);
        check("t5b_rst_pwm", pwm, 0);
        @(posedge clk); #1 rst = 0;

        // Randomized traffic against the model
        for (int k = 0; k < 12000; k++) begin
            int sel;
            @(posedge clk); #1;
            sel = int'($urandom_range(0, 1));
            bus.cfg_write   = ($urandom_range(0, 19) == 0);
            bus.cfg_channel = CB'($urandom_range(0, 3));
            bus.cfg_select  = sel[0];
            if (sel == 1) bus.cfg_data = ($urandom_range(0, 3) == 0) ? 8'd0 : W'($urandom_range(1, 80));
            else          bus.cfg_data = W'($urandom);
            dclr = ($urandom_range(0, 30) == 0) ? CH'($urandom) : '0;
            if (en && $urandom_range(0, 999) == 0)      en = 0;
            else if (!en && $urandom_range(0, 49) == 0) en = 1;
            rst = ($urandom_range(0, 4999) == 0);
        end
        @(posedge clk); #1;
        bus.cfg_write = 0; dclr = '0; rst = 0;
        @(negedge clk);
        chk_en = 0;

        // 6: prescaled timebase, TOP=200
        @(negedge clk);
        check("t6_reset_cur", cur2, 0);
        check("t6_reset_pwm", pwm2, 0);
        @(posedge clk); #1 rst2 = 0;
        @(posedge clk); #1;
        bus2.cfg_write = 1; bus2.cfg_channel = 1'b0; bus2.cfg_select = 0; bus2.cfg_data = 8'd100;
        @(posedge clk); #1 bus2.cfg_write = 0;
        en2 = 1;
        @(negedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps2 !== 1'b1 && n < 2000);
        check("t6_first_period", n, 800);
        check("t6_cur", cur2[7:0], 100);
        hi = 0; pc = 0; run = 0; maxrun = 0;
        for (int k = 0; k < 800; k++) begin
            if (pwm2[0]) begin
                hi++; run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (k > 0 && ps2) pc++;
            @(negedge clk);
        end
        check("t6_high_clocks", hi, 400);
        check("t6_high_consecutive", maxrun, 400);
        check("t6_no_early_pstart", pc, 0);
        check("t6_period_800", ps2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
